// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle integer ops plus an iterative 1-bit/cycle
// multiplier/divider for the M extension, with a valid/ready handshake.
module alu_seq #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      alucode,
    input  logic [XLEN-1:0] opr1,
    input  logic [XLEN-1:0] opr2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_result,
    output logic            br_taken,
    output logic            busy
);

    localparam logic [5:0] ALU_LUI    = 6'd0;
    localparam logic [5:0] ALU_JAL    = 6'd1;
    localparam logic [5:0] ALU_JALR   = 6'd2;
    localparam logic [5:0] ALU_BEQ    = 6'd3;
    localparam logic [5:0] ALU_BNE    = 6'd4;
    localparam logic [5:0] ALU_BLT    = 6'd5;
    localparam logic [5:0] ALU_BGE    = 6'd6;
    localparam logic [5:0] ALU_BLTU   = 6'd7;
    localparam logic [5:0] ALU_BGEU   = 6'd8;
    localparam logic [5:0] ALU_LB     = 6'd9;
    localparam logic [5:0] ALU_LH     = 6'd10;
    localparam logic [5:0] ALU_LW     = 6'd11;
    localparam logic [5:0] ALU_LBU    = 6'd12;
    localparam logic [5:0] ALU_LHU    = 6'd13;
    localparam logic [5:0] ALU_SB     = 6'd14;
    localparam logic [5:0] ALU_SH     = 6'd15;
    localparam logic [5:0] ALU_SW     = 6'd16;
    localparam logic [5:0] ALU_ADD    = 6'd17;
    localparam logic [5:0] ALU_SUB    = 6'd18;
    localparam logic [5:0] ALU_SLT    = 6'd19;
    localparam logic [5:0] ALU_SLTU   = 6'd20;
    localparam logic [5:0] ALU_XOR    = 6'd21;
    localparam logic [5:0] ALU_OR     = 6'd22;
    localparam logic [5:0] ALU_AND    = 6'd23;
    localparam logic [5:0] ALU_SLL    = 6'd24;
    localparam logic [5:0] ALU_SRL    = 6'd25;
    localparam logic [5:0] ALU_SRA    = 6'd26;
    localparam logic [5:0] ALU_MUL    = 6'd40;
    localparam logic [5:0] ALU_MULH   = 6'd41;
    localparam logic [5:0] ALU_MULHSU = 6'd42;
    localparam logic [5:0] ALU_MULHU  = 6'd43;
    localparam logic [5:0] ALU_DIV    = 6'd44;
    localparam logic [5:0] ALU_DIVU   = 6'd45;
    localparam logic [5:0] ALU_REM    = 6'd46;
    localparam logic [5:0] ALU_REMU   = 6'd47;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN-1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [SHW-1:0]    cnt_q, cnt_d;
    logic [5:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              br_q, br_d;

    logic              accept;
    logic              is_mop, is_div, div_zero, div_ovf, fast;
    logic              sgn1, sgn2, neg1, neg2;
    logic [XLEN-1:0]   mag1, mag2;
    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   imm_res;
    logic              imm_br;
    logic              last;

    logic              op_is_div;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [XLEN-1:0]   step_acc, step_lo, quo, rem;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   calc_res;

    assign accept = in_valid && in_ready;
    assign last   = (state_q == CALC) && (cnt_q == CNT_LAST);
    assign shamt  = opr2[SHW-1:0];

    // Request decode; division by zero and signed overflow bypass the iterative unit.
    always_comb begin
        is_mop   = (alucode >= ALU_MUL) && (alucode <= ALU_REMU);
        is_div   = (alucode >= ALU_DIV) && (alucode <= ALU_REMU);
        div_zero = is_div && (opr2 == '0);
        div_ovf  = ((alucode == ALU_DIV) || (alucode == ALU_REM)) &&
                   (opr1 == MOST_NEG) && (opr2 == '1);
        fast     = !is_mop || div_zero || div_ovf;
        sgn1     = (alucode == ALU_MULH) || (alucode == ALU_MULHSU) ||
                   (alucode == ALU_DIV)  || (alucode == ALU_REM);
        sgn2     = (alucode == ALU_MULH) || (alucode == ALU_DIV) || (alucode == ALU_REM);
        neg1     = sgn1 && opr1[XLEN-1];
        neg2     = sgn2 && opr2[XLEN-1];
        mag1     = neg1 ? -opr1 : opr1;
        mag2     = neg2 ? -opr2 : opr2;
    end

    always_comb begin
        imm_res = '0;
        imm_br  = 1'b0;
        case (alucode)
            ALU_LUI:            imm_res = opr2;
            ALU_JAL, ALU_JALR: begin
                imm_res = opr2 + XLEN'(4);
                imm_br  = 1'b1;
            end
            ALU_BEQ:            imm_br = (opr1 == opr2);
            ALU_BNE:            imm_br = (opr1 != opr2);
            ALU_BLT:            imm_br = ($signed(opr1) <  $signed(opr2));
            ALU_BGE:            imm_br = ($signed(opr1) >= $signed(opr2));
            ALU_BLTU:           imm_br = (opr1 <  opr2);
            ALU_BGEU:           imm_br = (opr1 >= opr2);
            ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU,
            ALU_SB, ALU_SH, ALU_SW, ALU_ADD:
                                imm_res = opr1 + opr2;
            ALU_SUB:            imm_res = opr1 - opr2;
            ALU_SLT:            imm_res = {{(XLEN-1){1'b0}}, $signed(opr1) < $signed(opr2)};
            ALU_SLTU:           imm_res = {{(XLEN-1){1'b0}}, opr1 < opr2};
            ALU_XOR:            imm_res = opr1 ^ opr2;
            ALU_OR:             imm_res = opr1 | opr2;
            ALU_AND:            imm_res = opr1 & opr2;
            ALU_SLL:            imm_res = opr1 << shamt;
            ALU_SRL:            imm_res = opr1 >> shamt;
            ALU_SRA:            imm_res = $unsigned($signed(opr1) >>> shamt);
            ALU_DIV:            imm_res = div_zero ? '1 : opr1;
            ALU_DIVU:           imm_res = '1;
            ALU_REM:            imm_res = div_zero ? opr1 : '0;
            ALU_REMU:           imm_res = opr1;
            default:            ;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide on magnitudes,
    // with the sign fix-up applied to the final iteration's result.
    always_comb begin
        op_is_div = (op_q >= ALU_DIV) && (op_q <= ALU_REMU);
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (op_is_div) begin
            step_acc = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_acc = mul_sum[XLEN:1];
            step_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        prod = {step_acc, step_lo};
        if (neg_q) begin
            prod = -prod;
        end
        quo = neg_q ? -step_lo : step_lo;
        rem = neg_q ? -step_acc : step_acc;
        case (op_q)
            ALU_MUL:                          calc_res = prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  calc_res = prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:                calc_res = quo;
            default:                          calc_res = rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) state_d = fast ? DONE : CALC;
                CALC: if (last)   state_d = DONE;
                DONE: begin
                    if (accept) begin
                        state_d = fast ? DONE : CALC;
                    end else if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready   = !flush && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
        out_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
        alu_result = res_q;
        br_taken   = br_q;
    end

    // Datapath next-state; operands are only captured on accept, so CALC ignores input changes.
    always_comb begin
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        br_d    = br_q;
        if (flush) begin
            cnt_d = '0;
            res_d = '0;
            br_d  = 1'b0;
        end else if (accept) begin
            cnt_d = '0;
            if (fast) begin
                res_d = imm_res;
                br_d  = imm_br;
            end else begin
                op_d  = alucode;
                acc_d = '0;
                if (is_div) begin
                    lo_d    = mag1;
                    mcand_d = mag2;
                    neg_d   = (alucode == ALU_REM) ? neg1 : (neg1 ^ neg2);
                end else begin
                    lo_d    = mag2;
                    mcand_d = mag1;
                    neg_d   = neg1 ^ neg2;
                end
            end
        end else if (state_q == CALC) begin
            cnt_d = cnt_q + SHW'(1);
            acc_d = step_acc;
            lo_d  = step_lo;
            if (last) begin
                cnt_d = '0;
                res_d = calc_res;
                br_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            br_q    <= br_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, then random ops
// compared against an arithmetic reference model.
module tb_alu_seq;

    localparam logic [5:0] ALU_LUI = 6'd0,  ALU_JAL = 6'd1,  ALU_JALR = 6'd2;
    localparam logic [5:0] ALU_BEQ = 6'd3,  ALU_BNE = 6'd4,  ALU_BLT = 6'd5,  ALU_BGE = 6'd6;
    localparam logic [5:0] ALU_BLTU = 6'd7, ALU_BGEU = 6'd8;
    localparam logic [5:0] ALU_LW = 6'd11,  ALU_SW = 6'd16;
    localparam logic [5:0] ALU_ADD = 6'd17, ALU_SUB = 6'd18, ALU_SLT = 6'd19, ALU_SLTU = 6'd20;
    localparam logic [5:0] ALU_XOR = 6'd21, ALU_OR = 6'd22,  ALU_AND = 6'd23;
    localparam logic [5:0] ALU_SLL = 6'd24, ALU_SRL = 6'd25, ALU_SRA = 6'd26;
    localparam logic [5:0] ALU_MUL = 6'd40, ALU_MULH = 6'd41, ALU_MULHSU = 6'd42, ALU_MULHU = 6'd43;
    localparam logic [5:0] ALU_DIV = 6'd44, ALU_DIVU = 6'd45, ALU_REM = 6'd46,   ALU_REMU = 6'd47;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  alucode = '0;
    logic [31:0] opr1 = '0;
    logic [31:0] opr2 = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_result;
    logic        br_taken;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucode    (alucode),
        .opr1       (opr1),
        .opr2       (opr2),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_result (alu_result),
        .br_taken   (br_taken),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built from the arithmetic definitions using 64-bit integers.
    function automatic void modelOp(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output logic br, output int lat);
        longint sa, sb, ua, ub, p;
        logic [63:0] pu;
        logic [4:0] sh;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        sh  = b[4:0];
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        res = '0;
        br  = 1'b0;
        lat = 1;
        case (code)
            ALU_LUI:           res = b;
            ALU_JAL, ALU_JALR: begin res = b + 32'd4; br = 1'b1; end
            ALU_BEQ:           br = (a == b);
            ALU_BNE:           br = (a != b);
            ALU_BLT:           br = (sa < sb);
            ALU_BGE:           br = (sa >= sb);
            ALU_BLTU:          br = (ua < ub);
            ALU_BGEU:          br = (ua >= ub);
            6'd9, 6'd10, ALU_LW, 6'd12, 6'd13, 6'd14, 6'd15, ALU_SW, ALU_ADD: res = a + b;
            ALU_SUB:           res = a - b;
            ALU_SLT:           res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:          res = (ua < ub) ? 32'd1 : 32'd0;
            ALU_XOR:           res = a ^ b;
            ALU_OR:            res = a | b;
            ALU_AND:           res = a & b;
            ALU_SLL:           res = a << sh;
            ALU_SRL:           res = a >> sh;
            ALU_SRA: begin
                res = a >> sh;
                if (a[31]) res = res | ~(32'hFFFF_FFFF >> sh);
            end
            ALU_MUL:    begin p = sa * sb; res = p[31:0];  lat = 33; end
            ALU_MULH:   begin p = sa * sb; res = p[63:32]; lat = 33; end
            ALU_MULHSU: begin p = sa * ub; res = p[63:32]; lat = 33; end
            ALU_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; res = pu[63:32]; lat = 33; end
            ALU_DIV: begin
                if (b == 0)   res = 32'hFFFF_FFFF;
                else if (ovf) res = a;
                else begin p = sa / sb; res = p[31:0]; lat = 33; end
            end
            ALU_DIVU: begin
                if (b == 0) res = 32'hFFFF_FFFF;
                else begin p = ua / ub; res = p[31:0]; lat = 33; end
            end
            ALU_REM: begin
                if (b == 0)   res = a;
                else if (ovf) res = 32'd0;
                else begin p = sa % sb; res = p[31:0]; lat = 33; end
            end
            ALU_REMU: begin
                if (b == 0) res = a;
                else begin p = ua % ub; res = p[31:0]; lat = 33; end
            end
            default: ;
        endcase
    endfunction

    // Issues one request from IDLE (called at a falling edge) and checks the
    // latency, result and branch flag; leaves the block waiting in DONE.
    task automatic applyStimulus(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp_res;
        logic exp_br;
        int exp_lat;
        int cycles;
        modelOp(code, a, b, exp_res, exp_br, exp_lat);
        alucode  = code;
        opr1     = a;
        opr2     = b;
        in_valid = 1'b1;
        #1;
        checkOutput("in_ready_idle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        alucode = 6'($urandom_range(0, 47));
        opr1    = $urandom;
        opr2    = $urandom;
        cycles  = 1;
        while (!out_valid && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        in_valid = 1'b0;
        checkOutput($sformatf("latency op%0d", code), cycles, exp_lat);
        checkOutput($sformatf("result op%0d", code), alu_result, exp_res);
        checkOutput($sformatf("br_taken op%0d", code), br_taken, exp_br);
    endtask

    task automatic completeOp();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0] code;
        logic [31:0] a, b;
        int seen;

        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset alu_result", alu_result, 0);
        checkOutput("reset br_taken", br_taken, 0);
        checkOutput("reset busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after reset", in_ready, 1);
        @(negedge clk);

        applyStimulus(ALU_ADD, 32'd7, 32'd5);              completeOp();
        applyStimulus(ALU_SLT, 32'hFFFF_FFFF, 32'd1);      completeOp();
        applyStimulus(ALU_SLTU, 32'hFFFF_FFFF, 32'd1);     completeOp();
        applyStimulus(ALU_SRA, 32'h8000_0000, 32'd4);      completeOp();
        applyStimulus(ALU_SRL, 32'h8000_0000, 32'd4);      completeOp();
        applyStimulus(ALU_MULH, 32'h8000_0000, 32'h8000_0000); completeOp();
        applyStimulus(ALU_DIV, -32'sd7, 32'd2);            completeOp();
        applyStimulus(ALU_REM, -32'sd7, 32'd2);            completeOp();
        applyStimulus(ALU_DIVU, 32'd5, 32'd0);             completeOp();
        applyStimulus(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF); completeOp();
        applyStimulus(6'd33, 32'd9, 32'd9);                completeOp();
        checkOutput("ADD 7+5 value", 32'd7 + 32'd5, 32'd12);

        // Flush ten cycles into a multiply.
        alucode = ALU_MUL; opr1 = 32'd123; opr2 = 32'd456; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("busy in CALC", busy, 1);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checkOutput("in_ready during flush", in_ready, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("busy after flush", busy, 0);
        seen = 0;
        repeat (40) begin
            if (out_valid) seen++;
            @(negedge clk);
        end
        checkOutput("out_valid after flush", seen, 0);

        // Asynchronous reset mid-divide, after a jump left a nonzero result behind.
        applyStimulus(ALU_JAL, 32'd0, 32'h0000_1000);      completeOp();
        alucode = ALU_DIV; opr1 = 32'd1000; opr2 = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async reset out_valid", out_valid, 0);
        checkOutput("async reset alu_result", alu_result, 0);
        checkOutput("async reset br_taken", br_taken, 0);
        checkOutput("async reset busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("in_ready after mid reset", in_ready, 1);
        @(negedge clk);

        // Result held while the consumer stalls, then a back-to-back branch.
        applyStimulus(ALU_SUB, 32'd100, 32'd58);
        repeat (5) begin
            @(negedge clk);
            checkOutput("hold out_valid", out_valid, 1);
            checkOutput("hold alu_result", alu_result, 32'd42);
        end
        alucode = ALU_BEQ; opr1 = 32'd3; opr2 = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checkOutput("in_ready back-to-back", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        checkOutput("b2b out_valid", out_valid, 1);
        checkOutput("b2b br_taken", br_taken, 1);
        checkOutput("b2b alu_result", alu_result, 0);
        completeOp();

        // Random operations, biased towards divide corner cases.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 3))
                0:       code = 6'($urandom_range(40, 47));
                1:       code = 6'($urandom_range(27, 63));
                default: code = 6'($urandom_range(0, 26));
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
                default: ;
            endcase
            applyStimulus(code, a, b);
            completeOp();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width, legal values 32 and 64.
REQ-002 SHALL have parameter SHW, default $clog2(XLEN): shift-amount width taken from opr2 LSBs.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  block can accept a request this cycle.
REQ-007 SHALL have port alucode  input  6  operation select: existing ALU_* codes from define.vh, plus new codes ALU_MUL=6'd40, ALU_MULH=41, ALU_MULHSU=42, ALU_MULHU=43, ALU_DIV=44, ALU_DIVU=45, ALU_REM=46, ALU_REMU=47.
REQ-008 SHALL have port opr1  input  XLEN  first operand.
REQ-009 SHALL have port opr2  input  XLEN  second operand.
REQ-010 SHALL have port flush  input  1  abandon the in-flight operation.
REQ-011 SHALL have port out_valid  output  1  result available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-013 SHALL have port alu_result  output  XLEN  registered result.
REQ-014 SHALL have port br_taken  output  1  registered branch decision.
REQ-015 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE.
REQ-017 SHALL accept a request when in_valid && in_ready; in_ready = !flush && (IDLE || (DONE && out_ready)).
REQ-018 SHALL, on accept of a non-M op or an M-op special case (REQ-024, REQ-025), register the result and enter DONE: out_valid in the cycle after accept (latency 1).
REQ-019 SHALL, on accept of an M op, latch operands and enter CALC with counter=0; advance 1 bit/cycle; on counter==XLEN-1 enter DONE: out_valid XLEN+1 cycles after accept.
REQ-020 SHALL, in DONE, hold out_valid, alu_result and br_taken stable until out_ready; on out_ready go to IDLE, or reload directly if a new request is accepted in the same cycle (back-to-back).
REQ-021 SHALL compute: SLT/BLT/BGE signed; SLTU/BLTU/BGEU unsigned; SLL logical left; SRL logical right; SRA arithmetic right; shift amount = opr2[SHW-1:0].
REQ-022 SHALL produce alu_result=opr2+4 and br_taken=1 for JAL/JALR; alu_result=0 for branches; alu_result=opr1+opr2 for load/store codes; alu_result=opr2 for LUI; br_taken=0 for every non-branch, non-jump op.
REQ-023 SHALL produce: MUL = low XLEN bits of the product; MULH/MULHSU/MULHU = high XLEN bits of the signed×signed, signed×unsigned and unsigned×unsigned 2·XLEN-bit product; DIV/DIVU = quotient truncated toward zero; REM/REMU = remainder with the sign of the dividend.
REQ-024 SHALL, when the divisor is 0, return quotient all-ones and remainder opr1, at latency 1.
REQ-025 SHALL, for signed overflow (opr1 = most-negative value, opr2 = -1), return DIV = opr1 and REM = 0, at latency 1.
REQ-026 SHALL return alu_result=0 and br_taken=0 for undefined alucode, at latency 1.
REQ-027 SHALL, on flush, go to IDLE in the next cycle, deassert out_valid and discard any result; flush overrides out_ready and in_valid in the same cycle.
REQ-028 SHALL ignore in_valid and operand changes while in CALC.

Reset
REQ-029 SHALL, on rst_n low at any time including mid-CALC, immediately set state=IDLE, counter=0, out_valid=0, alu_result=0, br_taken=0 and busy=0.
REQ-030 SHALL drive in_ready=1 in the first cycle after rst_n deasserts, provided flush=0.

Verification
REQ-031 SHALL test: ADD 7+5 accepted in cycle N -> out_valid=1, alu_result=12, br_taken=0 in cycle N+1.
REQ-032 SHALL test: SLT with opr1=0xFFFFFFFF, opr2=1 -> 1; SLTU with the same operands -> 0; SRA of 0x80000000 by 4 -> 0xF8000000; SRL of 0x80000000 by 4 -> 0x08000000.
REQ-033 SHALL test, at XLEN=32: MULH of 0x80000000 by 0x80000000 -> 0x40000000, out_valid 33 cycles after accept; DIV of -7 by 2 -> -3; REM of -7 by 2 -> -1.
REQ-034 SHALL test: DIVU of 5 by 0 -> 0xFFFFFFFF, latency 1; REM of 0x80000000 by -1 -> 0.
REQ-035 SHALL test: flush at CALC cycle 10 -> IDLE next cycle with out_valid never asserted; rst_n low mid-CALC -> all outputs 0 asynchronously.
REQ-036 SHALL test: out_ready held low 5 cycles in DONE -> result held stable; BEQ 3,3 issued with out_ready=1 -> accepted back-to-back, br_taken=1 on the next cycle.
